// File: rtl/surf_sync_receiver.sv
// SURF-side SYNC receiver: qualifies low-run + rising edge, realigns 16-phase and 48-bit counters.
// Sync cycle is SYNC_LATENCY cycles after the first high sample of sync_q.
module surf_sync_receiver #(
  parameter int MIN_LOW      = 4,
  parameter int SYNC_LATENCY = 4
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        SYNC,
  input  logic        en_sync_i,
  input  logic [7:0]  clock_offset_i,
  output logic [47:0] sysclk_count_o,
  output logic [3:0]  phase_o,
  output logic        sync_o,
  output logic        synced_o,
  output logic        misalign_o,
  output logic [7:0]  misalign_count_o,
  output logic        surf_clk_o
);

  localparam logic [2:0] LP_MIN_LOW = 3'(MIN_LOW);
  localparam logic [2:0] LP_CD_LOAD = 3'(SYNC_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync_q;
  logic        r_sync_prev;
  logic        r_en_meta;
  logic        r_en_sync;
  logic [7:0]  r_offset;
  logic [2:0]  r_lowcnt;
  logic [2:0]  w_lowcnt_nxt;
  logic [2:0]  r_cd;
  logic [2:0]  w_cd_nxt;
  logic [3:0]  r_phase;
  logic [3:0]  w_phase_nxt;
  logic [47:0] r_count;
  logic [47:0] w_count_nxt;
  logic        r_sync;
  logic        r_synced;
  logic        r_misalign;
  logic [7:0]  r_mcount;
  logic        r_surf_clk;
  logic        w_fire;
  logic        w_edge;
  logic        w_misalign_nxt;
  logic [2:0]  w_lowcnt_inc;

  assign w_edge       = r_sync_q & ~r_sync_prev;
  assign w_lowcnt_inc = (r_lowcnt >= LP_MIN_LOW) ? LP_MIN_LOW : r_lowcnt + 3'd1;

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Disarm overrides everything, including a sync that would fire this cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_lowcnt_nxt = r_lowcnt;
    w_cd_nxt     = r_cd;
    w_fire       = 1'b0;
    if (!r_en_sync) begin
      w_state_nxt  = ST_IDLE;
      w_lowcnt_nxt = 3'd0;
      w_cd_nxt     = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_ARMED;
          w_lowcnt_nxt = 3'd0;
        end
        ST_ARMED: begin
          if (!r_sync_q) begin
            w_lowcnt_nxt = w_lowcnt_inc;
          end else begin
            w_lowcnt_nxt = 3'd0;
            if (w_edge && (r_lowcnt >= LP_MIN_LOW)) begin
              w_state_nxt = ST_COUNT;
              w_cd_nxt    = LP_CD_LOAD;
            end
          end
        end
        ST_COUNT: begin
          w_cd_nxt = r_cd - 3'd1;
          if (!r_sync_q) begin
            w_state_nxt  = ST_ARMED;
            w_lowcnt_nxt = 3'd1;
            w_cd_nxt     = 3'd0;
          end else if (r_cd == 3'd1) begin
            w_fire      = 1'b1;
            w_state_nxt = ST_ARMED;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign w_phase_nxt    = w_fire ? 4'd0 : r_phase + 4'd1;
  assign w_count_nxt    = w_fire ? {40'b0, r_offset} : r_count + 48'd1;
  assign w_misalign_nxt = w_fire & r_synced & (r_phase != 4'd15);

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync_q    <= 1'b1;
      r_sync_prev <= 1'b1;
      r_en_meta   <= 1'b0;
      r_en_sync   <= 1'b0;
      r_offset    <= 8'd0;
      r_lowcnt    <= 3'd0;
      r_cd        <= 3'd0;
      r_phase     <= 4'd0;
      r_count     <= 48'd0;
      r_sync      <= 1'b0;
      r_synced    <= 1'b0;
      r_misalign  <= 1'b0;
      r_mcount    <= 8'd0;
      r_surf_clk  <= 1'b1;
    end else begin
      r_sync_q    <= SYNC;
      r_sync_prev <= r_sync_q;
      r_en_meta   <= en_sync_i;
      r_en_sync   <= r_en_meta;
      r_offset    <= clock_offset_i;
      r_lowcnt    <= w_lowcnt_nxt;
      r_cd        <= w_cd_nxt;
      r_phase     <= w_phase_nxt;
      r_count     <= w_count_nxt;
      r_sync      <= w_fire;
      r_misalign  <= w_misalign_nxt;
      r_surf_clk  <= ~w_phase_nxt[3];
      if (!r_en_sync) begin
        r_synced <= 1'b0;
      end else if (w_fire) begin
        r_synced <= 1'b1;
      end
      if (w_misalign_nxt && (r_mcount != 8'hFF)) begin
        r_mcount <= r_mcount + 8'd1;
      end
    end
  end

  // Lock status drops as soon as the resynchronised enable falls.
  assign synced_o         = r_synced & r_en_sync;
  assign sysclk_count_o   = r_count;
  assign phase_o          = r_phase;
  assign sync_o           = r_sync;
  assign misalign_o       = r_misalign;
  assign misalign_count_o = r_mcount;
  assign surf_clk_o       = r_surf_clk;

endmodule

// File: tb/tb_surf_sync_receiver.sv
// Directed bench for surf_sync_receiver with a tiny phase/count model.
module tb_surf_sync_receiver;

  logic        sysclk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        SYNC = 1'b1;
  logic        en_sync_i = 1'b0;
  logic [7:0]  clock_offset_i = 8'h2A;
  logic [47:0] sysclk_count_o;
  logic [3:0]  phase_o;
  logic        sync_o;
  logic        synced_o;
  logic        misalign_o;
  logic [7:0]  misalign_count_o;
  logic        surf_clk_o;

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  exp_ph = 4'd0;
  logic [47:0] exp_cnt = 48'd0;

  always #5 sysclk_i = ~sysclk_i;

  surf_sync_receiver dut (
    .sysclk_i         (sysclk_i),
    .rst_n_i          (rst_n_i),
    .SYNC             (SYNC),
    .en_sync_i        (en_sync_i),
    .clock_offset_i   (clock_offset_i),
    .sysclk_count_o   (sysclk_count_o),
    .phase_o          (phase_o),
    .sync_o           (sync_o),
    .synced_o         (synced_o),
    .misalign_o       (misalign_o),
    .misalign_count_o (misalign_count_o),
    .surf_clk_o       (surf_clk_o)
  );

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk_i);
      #1;
      exp_ph  = exp_ph + 4'd1;
      exp_cnt = exp_cnt + 48'd1;
    end
  endtask

  // Qualifying low run, rising edge driven when the local phase equals ph; ends in the sync cycle.
  task automatic sync_at(input logic [3:0] ph);
    SYNC = 1'b0;
    step(5);
    for (int i = 0; i < 16 && exp_ph != ph; i++) step(1);
    SYNC = 1'b1;
    step(5);
    exp_ph  = 4'd0;
    exp_cnt = {40'b0, clock_offset_i};
  endtask

  initial begin
    #2 rst_n_i = 1'b0;
    repeat (2) @(posedge sysclk_i);
    #1;
    chk("rst_phase", phase_o, 0);
    chk("rst_count", sysclk_count_o, 0);
    chk("rst_sync", sync_o, 0);
    chk("rst_synced", synced_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_mcount", misalign_count_o, 0);
    chk("rst_surfclk", surf_clk_o, 1);
    rst_n_i = 1'b1;
    exp_ph  = 4'd0;
    exp_cnt = 48'd0;
    step(3);
    chk("free_phase", phase_o, exp_ph);
    chk("free_count", sysclk_count_o, exp_cnt);

    en_sync_i = 1'b1;
    step(4);
    chk("armed_synced", synced_o, 0);

    // Qualified sync: low 5, then high; sync at R+4
    SYNC = 1'b0;
    step(5);
    SYNC = 1'b1;
    step(4);
    chk("q_early", sync_o, 0);
    step(1);
    chk("q_sync", sync_o, 1);
    chk("q_phase", phase_o, 0);
    chk("q_count", sysclk_count_o, 48'h2A);
    chk("q_synced", synced_o, 1);
    chk("q_misalign", misalign_o, 0);
    chk("q_surfclk", surf_clk_o, 1);
    exp_ph  = 4'd0;
    exp_cnt = 48'h2A;
    step(1);
    chk("q_count_next", sysclk_count_o, 48'h2B);
    chk("q_phase_next", phase_o, 1);
    chk("q_sync_drop", sync_o, 0);

    // Short low run
    SYNC = 1'b0;
    step(3);
    SYNC = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("short_nosync", sync_o, 0);
    end
    chk("short_phase", phase_o, exp_ph);
    chk("short_count", sysclk_count_o, exp_cnt);

    // Phase wrap and surf_clk mimic
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("wrap_phase", phase_o, exp_ph);
      chk("wrap_surfclk", surf_clk_o, (exp_ph < 4'd8));
    end

    // Glitch abort during COUNT
    SYNC = 1'b0;
    step(5);
    SYNC = 1'b1;
    step(2);
    SYNC = 1'b0;
    step(1);
    SYNC = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_nosync", sync_o, 0);
      chk("glitch_nomis", misalign_o, 0);
    end
    chk("glitch_phase", phase_o, exp_ph);

    // Misaligned sync, 5 cycles off grid, then an aligned one
    sync_at(4'd0);
    chk("mis_sync", sync_o, 1);
    chk("mis_pulse", misalign_o, 1);
    chk("mis_count", misalign_count_o, 1);
    chk("mis_phase", phase_o, 0);
    chk("mis_offset", sysclk_count_o, 48'h2A);
    step(1);
    chk("mis_pulse_drop", misalign_o, 0);
    sync_at(4'd11);
    chk("align_sync", sync_o, 1);
    chk("align_nomis", misalign_o, 0);
    chk("align_count", misalign_count_o, 1);
    chk("align_phase", phase_o, 0);

    // Disarm mid-COUNT
    SYNC = 1'b0;
    step(5);
    for (int i = 0; i < 16 && exp_ph != 4'd11; i++) step(1);
    SYNC = 1'b1;
    step(2);
    en_sync_i = 1'b0;
    step(2);
    chk("disarm_synced", synced_o, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("disarm_nosync", sync_o, 0);
    end
    chk("disarm_phase", phase_o, exp_ph);
    en_sync_i = 1'b1;
    step(4);
    chk("rearm_synced", synced_o, 0);

    // SYNC held low: nothing, then the saturated low run still qualifies
    SYNC = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("low_nosync", sync_o, 0);
    end
    SYNC = 1'b1;
    step(4);
    chk("long_early", sync_o, 0);
    step(1);
    chk("long_sync", sync_o, 1);
    chk("long_nomis", misalign_o, 0);
    chk("long_synced", synced_o, 1);
    exp_ph  = 4'd0;
    exp_cnt = 48'h2A;

    // Saturation of the misalignment counter
    for (int i = 0; i < 300; i++) begin
      sync_at(4'd0);
      if (i == 0) chk("sat_first_pulse", misalign_o, 1);
      if (i == 99) chk("sat_mid_count", misalign_count_o, 101);
    end
    chk("sat_count", misalign_count_o, 255);
    step(1);
    chk("sat_hold", misalign_count_o, 255);
    chk("sat_phase", phase_o, exp_ph);
    chk("sat_cnt", sysclk_count_o, exp_cnt);

    // Asynchronous reset mid-run
    step(9);
    chk("pre_rst_surfclk", surf_clk_o, 0);
    #3 rst_n_i = 1'b0;
    #1;
    chk("arst_phase", phase_o, 0);
    chk("arst_count", sysclk_count_o, 0);
    chk("arst_mcount", misalign_count_o, 0);
    chk("arst_surfclk", surf_clk_o, 1);
    chk("arst_synced", synced_o, 0);
    chk("arst_sync", sync_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/surf_sync_receiver.md
# surf_sync_receiver

Receive end of the TURFIO-to-SURF SYNC line. Qualifies the SYNC pattern: a low run of at least MIN_LOW clocks, then a rising edge. Restarts a local 16-phase counter and a 48-bit system-clock counter so that phase 0 lands on the same sysclk as the transmitter's phase 0. Reports lock and misalignment status for the SURF's sysclk domain.

## Interface
Parameters:
- MIN_LOW, 4: minimum qualifying low-run length in clocks; legal range 1–7.
- SYNC_LATENCY, 4: number of cycles from the first high sample to the phase-0 cycle; legal range 2–7.

Ports:
- sysclk_i  in  1  system clock; the only clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- SYNC  in  1  external sync line, idle high; captured in an IOB register (sync_q).
- en_sync_i  in  1  arm the receiver; quasi-static; resynchronised through 2 flops.
- clock_offset_i  in  8  value loaded into the counter on the sync cycle; quasi-static; 1-flop capture.
- sysclk_count_o  out  48  free-running system-clock count.
- phase_o  out  4  current clock phase, 0–15.
- sync_o  out  1  one-cycle pulse in each accepted sync cycle.
- synced_o  out  1  level; at least one sync accepted since armed.
- misalign_o  out  1  one-cycle pulse; accepted sync disagreed with the running phase.
- misalign_count_o  out  8  saturating misalignment count.
- surf_clk_o  out  1  phase mimic: high for phases 0–7, low for 8–15; IOB register.

## Operation
Reset values:
- sync_q=1, every counter 0, state IDLE.
- All outputs 0, except surf_clk_o=1 (phase 0).

Free-running behaviour:
- phase_o increments every cycle and wraps 15→0.
- sysclk_count_o increments every cycle and wraps modulo 2^48.
- Both keep running in every state.

State machine (en = en_sync_i after resynchronisation):
- IDLE: entered on reset or whenever en=0, from any state. synced_o is cleared. Leave to ARMED when en=1.
- ARMED: low-run counter lowcnt (3 bits, saturating at MIN_LOW) increments while sync_q=0 and clears while sync_q=1. The cycle with sync_q=1 whose previous sample was 0 is a rising edge.
  - Edge with lowcnt ≥ MIN_LOW: go to COUNT and load cd = SYNC_LATENCY−1.
  - Edge with a short low run: ignore it and stay in ARMED.
- COUNT: decrement cd every cycle.
  - If sync_q=0 in any COUNT cycle: abort to ARMED with lowcnt=1; no realignment.
  - When cd reaches 0 with sync_q still 1: the next cycle is the sync cycle; return to ARMED.

Sync cycle actions:
- phase_o=0.
- sysclk_count_o = {40'b0, clock_offset}.
- sync_o=1 for that cycle.
- synced_o is set.

Misalignment check:
- If synced_o was already 1 and phase_o in the preceding cycle was not 15, pulse misalign_o in the sync cycle.
- misalign_count_o increments, saturating at 255, and clears only on reset.

Other rules:
- surf_clk_o is registered from the next phase value, so it changes exactly on the 15→0 and 7→8 boundaries.
- If en falls in the same cycle as a sync cycle would occur, IDLE wins: no sync, synced_o cleared.

## Timing
Reference point: cycle R is the first cycle with sync_q=1.
- Sync cycle is R+SYNC_LATENCY.
- Total latency from the pin is one capture cycle plus SYNC_LATENCY.
- With defaults, this matches a transmitter that drives SYNC high in its phase 11: captured in phase 12, local phase 0 coincides with transmitter phase 0.

Other latencies:
- en_sync_i to state change: 2 cycles.
- Outputs change only on sysclk_i rising edges, except on assertion of rst_n_i, which clears asynchronously.

Boundary conditions:
- lowcnt saturates; a long low run is never lost to counter wrap.
- A repeated identical sync on an aligned stream (phase was 15) reloads the counter but raises no misalign.
- SYNC held low indefinitely produces no sync.
- SYNC toggling faster than MIN_LOW never qualifies.

## Test plan
- Qualified sync: reset, arm, drive SYNC low 5 cycles then high. Required: sync_o pulses at R+4, phase_o=0, sysclk_count_o=clock_offset_i (e.g. 0x2A), then 0x2B next cycle, synced_o=1, misalign_o stays 0.
- Short low: drive SYNC low for 3 cycles then high. Required: no sync_o and phase_o unchanged.
- Glitch abort: qualifying low run, then high for 2 cycles, then low for 1 cycle. Required: no sync and no misalign.
- Misalignment: after lock, issue a second sync placed 5 cycles off the 16-cycle grid. Required: misalign_o pulses, misalign_count_o=1, phase_o=0 at the new point. Issue a third, aligned sync: misalign_o stays 0.
- Disarm and reset: deassert en_sync_i mid-COUNT; required: synced_o=0 two cycles later and no sync. Separately, assert rst_n_i mid-run; required: all counters 0 and surf_clk_o=1 immediately.
- Saturation: 300 misaligned syncs. Required: misalign_count_o holds at 255.
